updown_mod_counter: RTL

Parametrised synchronous up/down modulo counter. It generalises the team's fixed 4-bit binary counter to any width and any modulus, and adds:
- direction control, count enable and synchronous clear;
- parallel load with range clamping;
- a terminal-count output for cascading, a registered wrap pulse and a Gray-coded output.

It is the counting element for the lab datapath and timer experiments, and instances are chained through `tc` to build multi-digit counters.

---
 rtl/updown_mod_counter.sv | 97 +++++++++
 1 files changed

// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with clamped parallel load, cascade
// terminal count, registered wrap/load-error pulses and a Gray-coded output.
module updown_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_gray,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO_VAL = '0;
  localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;

  // Next-state selection: clear > load > count > hold, with explicit modulo wrap.
  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (clear) begin
      count_d = ZERO_VAL;
    end else if (load) begin
      if (load_value > MAX_VAL) begin
        count_d    = MAX_VAL;
        load_err_d = 1'b1;
      end else begin
        count_d = load_value;
      end
    end else if (enable) begin
      if (up_down) begin
        if (count_q == MAX_VAL) begin
          count_d = ZERO_VAL;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + ONE_VAL;
        end
      end else begin
        if (count_q == ZERO_VAL) begin
          count_d = MAX_VAL;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - ONE_VAL;
        end
      end
    end else begin
      count_d = count_q;
    end
    // Gray code comes from the next value so it is registered alongside q.
    gray_d = bin2gray(count_d);
  end

  // State and pulse registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q    <= ZERO_VAL;
      gray_q     <= ZERO_VAL;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      gray_q     <= gray_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  // Terminal count is combinational so a downstream stage sees it in-cycle.
  always_comb begin
    tc = enable & ((up_down & (count_q == MAX_VAL)) |
                   (~up_down & (count_q == ZERO_VAL)));
  end

  assign q        = count_q;
  assign q_gray   = gray_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule
